uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_PER_HALF_BIT, default 86: clk cycles per half UART bit; minimum 2.
REQ-002 SHALL have parameter DATA_BITS, default 8: payload bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16: receive buffer entries; power of two, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port rd_en, input, 1 bit: pop the head entry.
REQ-009 SHALL have port dout, output, DATA_BITS bits: head entry, first-word-fall-through.
REQ-010 SHALL have port empty, output, 1 bit: buffer holds no entries.
REQ-011 SHALL have port full, output, 1 bit: buffer holds FIFO_DEPTH entries.
REQ-012 SHALL have port count, output, $clog2(FIFO_DEPTH)+1 bits: current number of entries.
REQ-013 SHALL have ports ferr, perr and overrun, each output, 1 bit: sticky error flags.
REQ-014 SHALL have port err_clr, input, 1 bit: clears all sticky flags.

Function
REQ-015 SHALL pass rxd through a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-016 SHALL implement receiver states IDLE, START, DATA, PAR, STOP.
REQ-017 IDLE: on a synchronized falling edge, SHALL go to START and load the bit timer with CLK_PER_HALF_BIT-1.
REQ-018 START: at timer expiry, SHALL go to DATA if the line is low; if the line is high (glitch), SHALL return to IDLE with no flag set.
REQ-019 DATA: SHALL sample every 2*CLK_PER_HALF_BIT cycles at mid-bit, LSB first, DATA_BITS samples; then SHALL go to PAR if PARITY != 0, else to STOP.
REQ-020 PAR: SHALL sample one bit; a mismatch with the even/odd parity of the data marks the frame as a parity error.
REQ-021 STOP: SHALL sample at mid-bit and then return to IDLE in the same cycle, so a start bit that immediately follows is detected.
REQ-022 Stop sample 0: SHALL set ferr and drop the frame.
REQ-023 Parity error with a valid stop bit: SHALL set perr and drop the frame.
REQ-024 Good frame: SHALL be written to the FIFO in the cycle after the stop sample; empty SHALL deassert one cycle after that write.
REQ-025 Good frame while full: SHALL be dropped and SHALL set overrun; exception: if rd_en is asserted in the same cycle, the write SHALL be accepted.
REQ-026 rd_en while empty: SHALL be ignored, with no pointer or count change.
REQ-027 Simultaneous push and pop on a non-empty FIFO: count SHALL be unchanged and dout SHALL advance.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 dout SHALL be undefined-but-stable while empty.
REQ-030 Flags SHALL remain set until err_clr; if err_clr and a new error occur in the same cycle, the flag SHALL stay set.

Reset
REQ-031 rst SHALL force: state IDLE, timer 0, pointers 0, count 0, empty=1, full=0, ferr=perr=overrun=0, synchronizer flops=1.
REQ-032 rst asserted mid-frame SHALL abort the frame, write nothing, and set no flag.
REQ-033 FIFO storage SHALL NOT be reset.

Structure
REQ-034 Package uart_pkg SHALL hold the rx_state_e enum and the parity encoding constants PAR_NONE, PAR_EVEN, PAR_ODD.
REQ-035 SHALL contain one sub-module, sync_fifo (parameters WIDTH, DEPTH; FWFT; exposes count), reusable by a future TX path.
REQ-036 SHALL contain no vendor IP cores and no second clock domain.

Verification
REQ-037 Bench SHALL use CLK_PER_HALF_BIT=4 and PARITY=0, and cover: send 0xA5 -> dout=0xA5 and empty falls 1 cycle after the stop-bit write; send 0x3C back-to-back with zero idle -> both received in order.
REQ-038 PARITY=1: send 0x07 with parity bit 0 -> perr=1, empty stays 1; then err_clr -> perr=0.
REQ-039 Stop bit forced low on 0x55 -> ferr=1, nothing written; a 2-cycle low glitch on idle rxd -> no flags and no write.
REQ-040 FIFO_DEPTH=4: send 5 frames with no reads -> count=4, full=1, overrun=1, dout=first byte; repeat with rd_en pulsed in the 5th write cycle -> overrun=0, count=4.
REQ-041 Assert rst in the middle of the DATA bits -> all outputs at reset values; the next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared receiver definitions: FSM state type, parity encodings and the
// expected-parity helper used by the RX decoder.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } rx_state_e;

    // Parity bit the transmitter should have sent, given the XOR of the data bits.
    function automatic logic par_expect(input logic data_xor, input int unsigned mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle of the receiver's serial input and FIFO read/status side.
// master = consumer driving rxd/rd_en/err_clr, slave = receiver side.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_W     = 5
);
    logic                 rxd;
    logic                 rd_en;
    logic                 err_clr;
    logic [DATA_BITS-1:0] dout;
    logic                 empty;
    logic                 full;
    logic [CNT_W-1:0]     count;
    logic                 ferr;
    logic                 perr;
    logic                 overrun;

    modport master (
        output rxd, rd_en, err_clr,
        input  dout, empty, full, count, ferr, perr, overrun
    );

    modport slave (
        input  rxd, rd_en, err_clr,
        output dout, empty, full, count, ferr, perr, overrun
    );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next pointer/count values; pointers wrap naturally at DEPTH (power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr && !rst) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1-style framing, optional parity) feeding a FWFT receive FIFO.
// Good frames are pushed the cycle after the stop sample; framing, parity and
// overrun conditions raise sticky flags cleared by err_clr.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_HALF_BIT = 86,
    parameter int unsigned DATA_BITS        = 8,
    parameter int unsigned PARITY           = 0,
    parameter int unsigned FIFO_DEPTH       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rxd,
    input  logic                        rd_en,
    output logic [DATA_BITS-1:0]        dout,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        ferr,
    output logic                        perr,
    output logic                        overrun,
    input  logic                        err_clr
);
    localparam int unsigned    TW       = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [TW-1:0]  HALF_M1  = TW'(CLK_PER_HALF_BIT - 1);
    localparam logic [TW-1:0]  FULL_M1  = TW'(2 * CLK_PER_HALF_BIT - 1);
    localparam int unsigned    BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q, prev_q;
    logic                 rxd_s;
    logic                 fall;
    rx_state_e            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 push_q, push_d;
    logic                 ferr_set, perr_set, ovr_set;
    logic                 ferr_q, perr_q, ovr_q;
    logic                 fifo_full;

    assign rxd_s = sync2_q;
    assign fall  = prev_q && !sync2_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver FSM: mid-bit sampling driven by a down-counting bit timer.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        push_d   = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    timer_d = HALF_M1;
                end
            end
            ST_START: begin
                if (timer_q == '0) begin
                    if (!rxd_s) begin
                        state_d = ST_DATA;
                        timer_d = FULL_M1;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    timer_d = FULL_M1;
                    if (bit_q == LAST_BIT) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_PAR: begin
                if (timer_q == '0) begin
                    par_d   = rxd_s;
                    timer_d = FULL_M1;
                    state_d = ST_STOP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == '0) begin
                    // Leave immediately so a start bit right after the stop bit is caught.
                    state_d = ST_IDLE;
                    if (!rxd_s) begin
                        ferr_set = 1'b1;
                    end else if ((PARITY != PAR_NONE) &&
                                 (par_q != par_expect(^shift_q, PARITY))) begin
                        perr_set = 1'b1;
                    end else begin
                        push_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Receiver state registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            push_q  <= push_d;
        end
    end

    // A push into a full FIFO is lost unless the consumer pops in the same cycle.
    assign ovr_set = push_q && fifo_full && !rd_en;

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_set || (ferr_q && !err_clr);
            perr_q <= perr_set || (perr_q && !err_clr);
            ovr_q  <= ovr_set  || (ovr_q  && !err_clr);
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data (shift_q),
        .rd_en   (rd_en),
        .rd_data (dout),
        .empty   (empty),
        .full    (fifo_full),
        .count   (count)
    );

    assign full    = fifo_full;
    assign ferr    = ferr_q;
    assign perr    = perr_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// frames checked against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int unsigned H       = 4;
    localparam int unsigned BIT_CYC = 2 * H;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   tgt_b = 1'b0;
    logic smp_empty_stop;
    logic [7:0] mq[$];
    logic m_ferr;
    logic m_ovr;

    uart_rx_fifo_if #(.DATA_BITS(8), .CNT_W(3)) ifa ();
    uart_rx_fifo_if #(.DATA_BITS(8), .CNT_W(5)) ifb ();

    uart_rx_fifo #(
        .CLK_PER_HALF_BIT (H),
        .DATA_BITS        (8),
        .PARITY           (PAR_NONE),
        .FIFO_DEPTH       (4)
    ) dut_a (
        .clk(clk), .rst(rst), .rxd(ifa.rxd), .rd_en(ifa.rd_en), .dout(ifa.dout),
        .empty(ifa.empty), .full(ifa.full), .count(ifa.count), .ferr(ifa.ferr),
        .perr(ifa.perr), .overrun(ifa.overrun), .err_clr(ifa.err_clr)
    );

    uart_rx_fifo #(
        .CLK_PER_HALF_BIT (H),
        .DATA_BITS        (8),
        .PARITY           (PAR_EVEN),
        .FIFO_DEPTH       (16)
    ) dut_b (
        .clk(clk), .rst(rst), .rxd(ifb.rxd), .rd_en(ifb.rd_en), .dout(ifb.dout),
        .empty(ifb.empty), .full(ifb.full), .count(ifb.count), .ferr(ifb.ferr),
        .perr(ifb.perr), .overrun(ifb.overrun), .err_clr(ifb.err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic set_rxd(input logic v);
        if (tgt_b) ifb.rxd = v; else ifa.rxd = v;
    endtask

    task automatic set_rd(input logic v);
        if (tgt_b) ifb.rd_en = v; else ifa.rd_en = v;
    endtask

    task automatic set_clr(input logic v);
        if (tgt_b) ifb.err_clr = v; else ifa.err_clr = v;
    endtask

    task automatic drive_bit(input logic v);
        set_rxd(v);
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd();
        set_rd(1'b1);
        @(posedge clk); #1;
        set_rd(1'b0);
    endtask

    task automatic pulse_clr();
        set_clr(1'b1);
        @(posedge clk); #1;
        set_clr(1'b0);
    endtask

    // Serial frame; optional err_clr on the stop-sample edge and rd_en on the write edge.
    task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par_val,
                              input logic stop_val, input logic clr_at_stop,
                              input logic rd_at_write);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (use_par) drive_bit(par_val);
        set_rxd(stop_val);
        repeat (BIT_CYC - 2) @(posedge clk);
        #1;
        if (clr_at_stop) set_clr(1'b1);
        @(posedge clk); #1;
        set_clr(1'b0);
        smp_empty_stop = tgt_b ? ifb.empty : ifa.empty;
        if (rd_at_write) set_rd(1'b1);
        @(posedge clk); #1;
        set_rd(1'b0);
        set_rxd(1'b1);
        if (!stop_val) drive_bit(1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.rxd = 1'b1; ifa.rd_en = 1'b0; ifa.err_clr = 1'b0;
        ifb.rxd = 1'b1; ifb.rd_en = 1'b0; ifb.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ifa.empty !== 1'b1) begin bad++; $display("FAIL rst_empty_a: got %b expected 1", ifa.empty); end
        total++; if (ifa.full !== 1'b0) begin bad++; $display("FAIL rst_full_a: got %b expected 0", ifa.full); end
        total++; if (ifa.count !== 3'd0) begin bad++; $display("FAIL rst_count_a: got %0d expected 0", ifa.count); end
        total++; if ({ifa.ferr, ifa.perr, ifa.overrun} !== 3'b000) begin bad++; $display("FAIL rst_flags_a: got %b expected 000", {ifa.ferr, ifa.perr, ifa.overrun}); end
        total++; if ({ifb.empty, ifb.full, ifb.count} !== 7'b1000000) begin bad++; $display("FAIL rst_fifo_b: got %b expected 1000000", {ifb.empty, ifb.full, ifb.count}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        tgt_b = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (smp_empty_stop !== 1'b1) begin bad++; $display("FAIL single_empty_at_stop: got %b expected 1", smp_empty_stop); end
        total++; if (ifa.empty !== 1'b0) begin bad++; $display("FAIL single_empty_after_write: got %b expected 0", ifa.empty); end
        total++; if (ifa.dout !== 8'hA5) begin bad++; $display("FAIL single_dout: got %0h expected a5", ifa.dout); end
        total++; if (ifa.count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d expected 1", ifa.count); end
        pulse_rd();
        total++; if (ifa.empty !== 1'b1) begin bad++; $display("FAIL single_pop_empty: got %b expected 1", ifa.empty); end
        pulse_rd();
        total++; if (ifa.count !== 3'd0) begin bad++; $display("FAIL rd_when_empty: got %0d expected 0", ifa.count); end
    endtask

    task automatic test_back_to_back();
        tgt_b = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (ifa.count !== 3'd2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", ifa.count); end
        total++; if (ifa.dout !== 8'h3C) begin bad++; $display("FAIL b2b_first: got %0h expected 3c", ifa.dout); end
        pulse_rd();
        total++; if (ifa.dout !== 8'h5A) begin bad++; $display("FAIL b2b_second: got %0h expected 5a", ifa.dout); end
        pulse_rd();
        total++; if (ifa.empty !== 1'b1) begin bad++; $display("FAIL b2b_drained: got %b expected 1", ifa.empty); end
    endtask

    task automatic test_parity();
        tgt_b = 1'b1;
        // 0x07 has three ones, so even parity requires a 1; sending 0 is an error.
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (ifb.perr !== 1'b1) begin bad++; $display("FAIL par_perr_set: got %b expected 1", ifb.perr); end
        total++; if (ifb.empty !== 1'b1) begin bad++; $display("FAIL par_dropped: got %b expected 1", ifb.empty); end
        total++; if (ifb.ferr !== 1'b0) begin bad++; $display("FAIL par_no_ferr: got %b expected 0", ifb.ferr); end
        pulse_clr();
        total++; if (ifb.perr !== 1'b0) begin bad++; $display("FAIL par_clr: got %b expected 0", ifb.perr); end
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (ifb.dout !== 8'h07 || ifb.empty !== 1'b0) begin bad++; $display("FAIL par_good: got dout=%0h empty=%b expected dout=07 empty=0", ifb.dout, ifb.empty); end
        total++; if (ifb.perr !== 1'b0) begin bad++; $display("FAIL par_good_flag: got %b expected 0", ifb.perr); end
        pulse_rd();
        tgt_b = 1'b0;
    endtask

    task automatic test_ferr_glitch();
        tgt_b = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (ifa.ferr !== 1'b1) begin bad++; $display("FAIL ferr_set: got %b expected 1", ifa.ferr); end
        total++; if (ifa.count !== 3'd0) begin bad++; $display("FAIL ferr_dropped: got %0d expected 0", ifa.count); end
        pulse_clr();
        total++; if (ifa.ferr !== 1'b0) begin bad++; $display("FAIL ferr_clr: got %b expected 0", ifa.ferr); end
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (ifa.ferr !== 1'b1) begin bad++; $display("FAIL ferr_set_beats_clr: got %b expected 1", ifa.ferr); end
        pulse_clr();
        set_rxd(1'b0);
        repeat (2) @(posedge clk);
        #1;
        set_rxd(1'b1);
        repeat (3 * BIT_CYC) @(posedge clk);
        #1;
        total++; if ({ifa.ferr, ifa.perr, ifa.overrun} !== 3'b000) begin bad++; $display("FAIL glitch_flags: got %b expected 000", {ifa.ferr, ifa.perr, ifa.overrun}); end
        total++; if (ifa.empty !== 1'b1) begin bad++; $display("FAIL glitch_no_write: got %b expected 1", ifa.empty); end
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (ifa.dout !== 8'h42) begin bad++; $display("FAIL glitch_recover: got %0h expected 42", ifa.dout); end
        pulse_rd();
    endtask

    task automatic test_overrun();
        logic [7:0] b [5];
        tgt_b = 1'b0;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) send_frame(b[i], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (ifa.count !== 3'd4) begin bad++; $display("FAIL ovr_count: got %0d expected 4", ifa.count); end
        total++; if (ifa.full !== 1'b1) begin bad++; $display("FAIL ovr_full: got %b expected 1", ifa.full); end
        total++; if (ifa.overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b expected 1", ifa.overrun); end
        for (int i = 0; i < 4; i++) begin
            total++; if (ifa.dout !== b[i]) begin bad++; $display("FAIL ovr_drain%0d: got %0h expected %0h", i, ifa.dout, b[i]); end
            pulse_rd();
        end
        pulse_clr();
        total++; if (ifa.overrun !== 1'b0 || ifa.empty !== 1'b1) begin bad++; $display("FAIL ovr_clr: got ovr=%b empty=%b expected ovr=0 empty=1", ifa.overrun, ifa.empty); end
        for (int i = 0; i < 5; i++) send_frame(b[i], 1'b0, 1'b0, 1'b1, 1'b0, i == 4);
        total++; if (ifa.overrun !== 1'b0) begin bad++; $display("FAIL ovr_rd_same_cycle: got %b expected 0", ifa.overrun); end
        total++; if (ifa.count !== 3'd4) begin bad++; $display("FAIL ovr_rd_count: got %0d expected 4", ifa.count); end
        for (int i = 1; i < 5; i++) begin
            total++; if (ifa.dout !== b[i]) begin bad++; $display("FAIL ovr_rd_drain%0d: got %0h expected %0h", i, ifa.dout, b[i]); end
            pulse_rd();
        end
    endtask

    task automatic test_reset_mid_frame();
        tgt_b = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst = 1'b1;
        set_rxd(1'b1);
        repeat (2) @(posedge clk);
        #1;
        total++; if ({ifa.empty, ifa.full, ifa.count} !== 5'b10000) begin bad++; $display("FAIL midrst_fifo: got %b expected 10000", {ifa.empty, ifa.full, ifa.count}); end
        total++; if ({ifa.ferr, ifa.perr, ifa.overrun} !== 3'b000) begin bad++; $display("FAIL midrst_flags: got %b expected 000", {ifa.ferr, ifa.perr, ifa.overrun}); end
        rst = 1'b0;
        repeat (3 * BIT_CYC) @(posedge clk);
        #1;
        total++; if (ifa.empty !== 1'b1 || ifa.ferr !== 1'b0) begin bad++; $display("FAIL midrst_nowrite: got empty=%b ferr=%b expected empty=1 ferr=0", ifa.empty, ifa.ferr); end
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (ifa.dout !== 8'h81 || ifa.count !== 3'd1) begin bad++; $display("FAIL midrst_next: got dout=%0h count=%0d expected dout=81 count=1", ifa.dout, ifa.count); end
        pulse_rd();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       stop_ok;
        int         npop;
        tgt_b  = 1'b0;
        mq.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        for (int n = 0; n < 30; n++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            send_frame(d, 1'b0, 1'b0, stop_ok, 1'b0, 1'b0);
            if (!stop_ok) m_ferr = 1'b1;
            else if (mq.size() == 4) m_ovr = 1'b1;
            else mq.push_back(d);
            total++; if (ifa.count !== 3'(mq.size())) begin bad++; $display("FAIL rnd%0d_count: got %0d expected %0d", n, ifa.count, mq.size()); end
            total++; if (ifa.ferr !== m_ferr || ifa.overrun !== m_ovr) begin bad++; $display("FAIL rnd%0d_flags: got ferr=%b ovr=%b expected ferr=%b ovr=%b", n, ifa.ferr, ifa.overrun, m_ferr, m_ovr); end
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) begin
                if (mq.size() > 0) begin
                    total++; if (ifa.dout !== mq[0]) begin bad++; $display("FAIL rnd%0d_dout: got %0h expected %0h", n, ifa.dout, mq[0]); end
                    void'(mq.pop_front());
                end
                pulse_rd();
            end
            total++; if (ifa.empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd%0d_empty: got %b expected %b", n, ifa.empty, mq.size() == 0); end
            if ($urandom_range(0, 5) == 0) begin
                pulse_clr();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_ferr_glitch();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
